// File: rtl/mem_sram_bridge.sv
// MEM-stage data bridge: turns one load/store into a single data_req/addr_ok/data_ok
// bus transaction, stalls MEM until it completes and holds the read data for the extractor.
module mem_sram_bridge #(
    parameter int unsigned PADDR_MAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [3:0]  mem_sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        except_flush,
    input  logic        pipe_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    logic   cancel;
    logic   cancel_now;

    // kseg0/kseg1 fold onto the low 512 MB of physical space
    function automatic logic [AW-1:0] paddr(input logic [AW-1:0] a);
        if ((PADDR_MAP != 0) && (a[31:30] == 2'b10)) begin
            return {3'b000, a[28:0]};
        end
        return a;
    endfunction

    // A flush arriving in the same cycle as data_ok still squashes the result
    assign cancel_now = cancel | except_flush;

    assign mem_stall = ~rst & (((state == S_IDLE) & mem_en & ~except_flush)
                               | (state == S_REQ) | (state == S_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cancel     <= 1'b0;
            mem_rdata  <= '0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cancel <= 1'b0;
                    if (mem_en && !except_flush) begin
                        data_req   <= 1'b1;
                        data_wr    <= mem_wr;
                        data_size  <= mem_size;
                        data_addr  <= paddr(mem_addr);
                        data_wstrb <= mem_wr ? mem_sel : 4'b0000;
                        data_wdata <= mem_wdata;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (except_flush) begin
                        cancel <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (cancel_now) begin
                            cancel <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            if (!data_wr) begin
                                mem_rdata <= data_rdata;
                            end
                            state <= S_DONE;
                        end
                    end else if (except_flush) begin
                        cancel <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!pipe_stall) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Bench for mem_sram_bridge: table of load/store vectors with a read-data scoreboard,
// plus hand sequences for DONE hold, flushes, back-to-back loads and async reset.
module tb_mem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_wr, except_flush, pipe_stall;
    logic [3:0]  mem_sel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  sel;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    mem_sram_bridge #(.PADDR_MAP(1)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .except_flush(except_flush), .pipe_stall(pipe_stall),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, mem_rdata, 32'h0);
        chk({tag, "_stall"}, 32'(mem_stall), 32'h0);
        chk({tag, "_req"},   32'(data_req), 32'h0);
        chk({tag, "_wr"},    32'(data_wr), 32'h0);
        chk({tag, "_size"},  32'(data_size), 32'h0);
        chk({tag, "_addr"},  data_addr, 32'h0);
        chk({tag, "_wstrb"}, 32'(data_wstrb), 32'h0);
        chk({tag, "_wdata"}, data_wdata, 32'h0);
    endtask

    // Starts in an IDLE cycle, returns in the DONE cycle with pipe_stall low
    task automatic do_txn(input vec_t v);
        logic [31:0] exp;
        mem_en = 1'b1; mem_wr = v.wr; mem_sel = v.sel; mem_size = v.size;
        mem_addr = v.addr; mem_wdata = v.wdata; except_flush = 1'b0; pipe_stall = 1'b0;
        #1;
        chk("stall_c0", 32'(mem_stall), 32'h1);
        chk("req_c0", 32'(data_req), 32'h0);
        if (!v.wr) model_rdata = v.rdata;
        exp_q.push_back(model_rdata);
        for (int k = 0; k <= v.lat; k++) begin
            step();
            data_addr_ok = (k == v.lat);
            data_data_ok = (k != v.lat);
            data_rdata   = ~v.rdata;
            #1;
            chk("req_held", 32'(data_req), 32'h1);
            chk("stall_req", 32'(mem_stall), 32'h1);
            chk("bus_addr", data_addr, v.exp_addr);
            chk("bus_wr", 32'(data_wr), 32'(v.wr));
            chk("bus_size", 32'(data_size), 32'(v.size));
            chk("bus_wstrb", 32'(data_wstrb), v.wr ? 32'(v.sel) : 32'h0);
            chk("bus_wdata", data_wdata, v.wdata);
        end
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v.rdata;
        #1;
        chk("req_wait", 32'(data_req), 32'h0);
        chk("stall_wait", 32'(mem_stall), 32'h1);
        step();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("stall_done", 32'(mem_stall), 32'h0);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            exp = exp_q.pop_front();
            chk("rdata_done", mem_rdata, exp);
        end
    endtask

    task automatic go_idle();
        step();
        mem_en = 1'b0;
        #1;
        chk("stall_idle", 32'(mem_stall), 32'h0);
    endtask

    initial begin
        vec_t v;
        // wr, sel, size, addr, wdata, rdata, addr_ok latency, expected physical addr
        vecs[0] = '{1'b0, 4'b1111, 2'b10, 32'hBFC00010, 32'h0, 32'h12345678, 0, 32'h1FC00010};
        vecs[1] = '{1'b1, 4'b1000, 2'b00, 32'h80000003, 32'hAAAAAAAA, 32'h0BADF00D, 3, 32'h00000003};
        vecs[2] = '{1'b1, 4'b1100, 2'b01, 32'h00001002, 32'hBEEFBEEF, 32'h11111111, 1, 32'h00001002};
        vecs[3] = '{1'b0, 4'b1111, 2'b10, 32'h40000000, 32'h0, 32'hDEADBEEF, 2, 32'h40000000};
        vecs[4] = '{1'b0, 4'b0010, 2'b00, 32'hA0000005, 32'h0, 32'h00FF0000, 0, 32'h00000005};
        vecs[5] = '{1'b0, 4'b1111, 2'b10, 32'hC0000004, 32'h0, 32'h55AA55AA, 1, 32'hC0000004};

        rst = 1'b1; mem_en = 1'b0; mem_wr = 1'b0; mem_sel = 4'h0; mem_size = 2'b00;
        mem_addr = 32'h0; mem_wdata = 32'h0; except_flush = 1'b0; pipe_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        model_rdata = 32'h0;
        #3;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
            go_idle();
        end

        // DONE held by pipe_stall: no new request, data stable
        v = '{1'b0, 4'b1111, 2'b10, 32'h80000100, 32'h0, 32'hCAFEF00D, 0, 32'h00000100};
        do_txn(v);
        pipe_stall = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'h77777777;
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            chk("hold_stall", 32'(mem_stall), 32'h0);
            chk("hold_req", 32'(data_req), 32'h0);
            chk("hold_rdata", mem_rdata, 32'hCAFEF00D);
        end
        pipe_stall = 1'b0; data_data_ok = 1'b0;
        go_idle();
        step();
        #1;
        chk("idle_noreq", 32'(data_req), 32'h0);

        // mem_en with flush in IDLE never issues a request
        mem_en = 1'b1; except_flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(mem_stall), 32'h0);
        step();
        #1;
        chk("flush_idle_req", 32'(data_req), 32'h0);
        mem_en = 1'b0; except_flush = 1'b0;

        // flush in WAIT: bus completes, stall holds until data_ok, rdata unchanged
        mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h00002000; mem_size = 2'b10; mem_sel = 4'hF;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; except_flush = 1'b1; mem_en = 1'b0;
        #1;
        chk("flush_wait_stall", 32'(mem_stall), 32'h1);
        step();
        except_flush = 1'b0;
        #1;
        chk("flush_wait_stall2", 32'(mem_stall), 32'h1);
        data_data_ok = 1'b1; data_rdata = 32'h99999999;
        step();
        data_data_ok = 1'b0;
        #1;
        chk("flush_after_stall", 32'(mem_stall), 32'h0);
        chk("flush_after_rdata", mem_rdata, model_rdata);
        chk("flush_after_req", 32'(data_req), 32'h0);

        // back-to-back loads; cancel must have cleared
        step();
        v = '{1'b0, 4'b1111, 2'b10, 32'h00000040, 32'h0, 32'h00000001, 0, 32'h00000040};
        do_txn(v);
        step();
        v = '{1'b0, 4'b1111, 2'b10, 32'h00000044, 32'h0, 32'h00000002, 1, 32'h00000044};
        do_txn(v);
        go_idle();

        // async reset in WAIT clears everything without a clock edge
        mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 32'h80001000; mem_wdata = 32'h5A5A5A5A; mem_sel = 4'hF;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; mem_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        rst = 1'b0;
        model_rdata = 32'h0;
        step();
        v = '{1'b0, 4'b1111, 2'b10, 32'h9FC00000, 32'h0, 32'h0F0F0F0F, 0, 32'h1FC00000};
        do_txn(v);
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
